sha256_chunk_hasher: RTL and testbench
======================================

Name: sha256_chunk_hasher

Overview:
Downstream consumer of the chunk processor's 512-bit chunk stream. Runs the SHA-256 compression function over each chunk, one or more rounds per cycle, and accumulates the intermediate hash state across the chunks of one context. After the context's last chunk it presents the 256-bit digest on a valid/ready output.

Parameters:
UNROLL, 1, rounds evaluated per clock; legal values 1, 2, 4; must divide 64. Any other value is an elaboration error.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset.
chunk_in_vld  input  1  chunk_in, chunk_first and chunk_last are valid.
chunk_in_rdy  output  1  block can accept a chunk this cycle.
chunk_in  input  512  message block, big-endian; word 0 is chunk_in[511:480].
chunk_first  input  1  chunk is the first of a context; reload H from IV before compressing.
chunk_last  input  1  chunk is the last of a context; emit digest after compressing.
digest_rdy  input  1  consumer accepts the digest.
digest_vld  output  1  digest is valid.
digest  output  256  final H0..H7; H0 is digest[255:224].
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; H0..H7=IV; chunk_in_rdy=0; digest_vld=0; digest=0; busy=0; round counter=0. Reset asserted mid-round or mid-digest drops all work; no partial digest is ever emitted.
- chunk_in_rdy is registered: 1 only in IDLE, 0 from the cycle after reset releases until IDLE is reached.
- States:
  - IDLE:
    - On chunk_in_vld&chunk_in_rdy: latch chunk_in into the 16x32 W window.
    - Latch flags.
    - Working vars a..h <= chunk_first ? IV : H; if chunk_first, H <= IV in the same edge.
    - Round counter t=0; go ROUNDS.
  - ROUNDS: each cycle apply UNROLL rounds t..t+UNROLL-1 using K[t] and W[t].
    - W[t] for t<16 is the window head.
    - W[t]=s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16] mod 2^32, computed from the sliding 16-word window, which shifts by UNROLL words per cycle.
    - t+=UNROLL; after the cycle where t reaches 64, go ACCUM.
  - ACCUM (1 cycle): Hi <= Hi + working var i, each mod 2^32. Go DIGEST if last flag set, else IDLE.
  - DIGEST: digest_vld=1 and digest=H, both registered and stable until digest_rdy.
    - On digest_vld&digest_rdy: digest_vld=0; H <= IV; go IDLE.
    - digest_rdy high on the entry cycle is honoured in that same cycle.
- Latency: handshake edge to ACCUM edge = 64/UNROLL + 1 cycles. digest_vld rises on the cycle after ACCUM.
- Throughput: one chunk per 64/UNROLL + 2 cycles with no backpressure.
- Arithmetic: all additions are 32-bit modulo 2^32 (carries dropped). Rotations/shifts follow FIPS 180-4:
  - S0 = ROTR2^ROTR13^ROTR22
  - S1 = ROTR6^ROTR11^ROTR25
  - s0 = ROTR7^ROTR18^SHR3
  - s1 = ROTR17^ROTR19^SHR10
- A chunk with both chunk_first and chunk_last is a one-block context.
- chunk_first on a chunk while the previous context never saw chunk_last: H is reloaded and the prior context is silently discarded.
- chunk_in_vld while not ready: no effect; the upstream holds its data. Inputs are not sampled outside IDLE.
- digest_rdy outside DIGEST is ignored.

Decomposition:
- sha256_pkg holds:
  - IV[0:7] and K[0:63] as 32-bit constant arrays.
  - The function set S0/S1/s0/s1/Ch/Maj.
  - HasherState enum {IDLE, ROUNDS, ACCUM, DIGEST}.
  - Typedef HashState (8x32 struct a..h).
- One sub-module, sha256_round: purely combinational, one round.
  - Inputs: HashState, Kt, Wt. Output: next HashState.
  - Instantiated UNROLL times in a chain.
- The W window and counters stay in the top module.

Test Plan:
- "abc" single block (chunk_in=0x61626380 followed by zeros ending 0x00000018), first=last=1, UNROLL=1, digest_rdy=1 -> digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad; digest_vld rises exactly 66 cycles after the handshake.
- Empty message (0x80000000, rest zero, length 0), first=last=1 -> digest=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Blocks 1 and 2 sent back-to-back; first=1 on block 1 only, last=1 on block 2 only.
  - Expected: exactly one digest_vld pulse, digest=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
  - chunk_in_rdy is 0 for the whole of block 1's compression.
- Backpressure:
  - Hold digest_rdy=0 for 20 cycles after digest_vld rises -> digest is stable and chunk_in_rdy stays 0.
  - On digest_rdy=1: handshake occurs; chunk_in_rdy=1 the next cycle.
  - A following "abc" context gives the correct digest, proving H was reloaded.
- Reset mid-operation: pull rst low at round 30 of a chunk -> asynchronously digest_vld=0, busy=0, chunk_in_rdy=0. After release, an "abc" context gives the correct digest.
- UNROLL=2 and UNROLL=4 builds rerun scenarios 1 and 3 -> identical digests. Handshake-to-digest_vld latency is 34 and 18 cycles respectively.

Source files
------------

// File: rtl/sha256_pkg.sv
// SHA-256 shared constants, round functions and types.
// Used by the chunk hasher top and its round sub-module.
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROUNDS,
        ACCUM,
        DIGEST
    } HasherState;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } HashState;

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam HashState IV_HS = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] sml_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sml_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, y, z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, y, z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
// Chained UNROLL times inside the chunk hasher.
module sha256_round
    import sha256_pkg::*;
(
    input  HashState    i_st,
    input  logic [31:0] i_kt,
    input  logic [31:0] i_wt,
    output HashState    o_st
);

    logic [31:0] w_t1;
    logic [31:0] w_t2;

    // Temporaries and working-variable rotation for one round
    always_comb begin
        w_t1 = i_st.h + big_s1(i_st.e) + ch(i_st.e, i_st.f, i_st.g)
             + i_kt + i_wt;
        w_t2 = big_s0(i_st.a) + maj(i_st.a, i_st.b, i_st.c);
        o_st.a = w_t1 + w_t2;
        o_st.b = i_st.a;
        o_st.c = i_st.b;
        o_st.d = i_st.c;
        o_st.e = i_st.d + w_t1;
        o_st.f = i_st.e;
        o_st.g = i_st.f;
        o_st.h = i_st.g;
    end

endmodule

// File: rtl/sha256_chunk_hasher.sv
// SHA-256 chunk hasher: compresses 512-bit chunks, UNROLL rounds
// per clock, accumulating H across a context and emitting a digest.
module sha256_chunk_hasher
    import sha256_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         chunk_in_vld,
    output logic         chunk_in_rdy,
    input  logic [511:0] chunk_in,
    input  logic         chunk_first,
    input  logic         chunk_last,
    input  logic         digest_rdy,
    output logic         digest_vld,
    output logic [255:0] digest,
    output logic         busy
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
        $error("sha256_chunk_hasher: UNROLL must be 1, 2 or 4");
    end

    HasherState   r_state;
    HashState     r_h;
    HashState     r_work;
    logic [31:0]  r_w [0:15];
    logic [6:0]   r_t;
    logic         r_last;
    logic         r_rdy;
    logic         r_vld;
    logic         r_busy;
    logic [255:0] r_digest;

    HashState     w_st [0:UNROLL];
    HashState     w_sum;
    logic [31:0]  w_nxt [0:15];

    assign w_st[0] = r_work;

    for (genvar g = 0; g < UNROLL; g++) begin : g_rnd
        logic [5:0] w_ki;
        assign w_ki = r_t[5:0] + 6'(g);
        sha256_round u_round (
            .i_st (w_st[g]),
            .i_kt (K[w_ki]),
            .i_wt (r_w[g]),
            .o_st (w_st[g+1])
        );
    end

    // Message schedule: extend window by UNROLL words, then slide
    always_comb begin
        logic [31:0] ext [0:19];
        for (int j = 0; j < 16; j++) ext[j] = r_w[j];
        for (int j = 16; j < 20; j++) ext[j] = '0;
        for (int k = 0; k < UNROLL; k++) begin
            ext[16+k] = sml_s1(ext[14+k]) + ext[9+k]
                      + sml_s0(ext[1+k]) + ext[k];
        end
        for (int j = 0; j < 16; j++) w_nxt[j] = ext[j+UNROLL];
    end

    // Chunk feed-forward: H plus final working variables
    always_comb begin
        w_sum.a = r_h.a + r_work.a;
        w_sum.b = r_h.b + r_work.b;
        w_sum.c = r_h.c + r_work.c;
        w_sum.d = r_h.d + r_work.d;
        w_sum.e = r_h.e + r_work.e;
        w_sum.f = r_h.f + r_work.f;
        w_sum.g = r_h.g + r_work.g;
        w_sum.h = r_h.h + r_work.h;
    end

    // Control FSM with registered handshake and status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_h      <= IV_HS;
            r_work   <= '0;
            for (int j = 0; j < 16; j++) r_w[j] <= '0;
            r_t      <= '0;
            r_last   <= 1'b0;
            r_rdy    <= 1'b0;
            r_vld    <= 1'b0;
            r_busy   <= 1'b0;
            r_digest <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_rdy <= 1'b1;
                    if (chunk_in_vld && r_rdy) begin
                        for (int j = 0; j < 16; j++) begin
                            r_w[j] <= chunk_in[511-32*j -: 32];
                        end
                        r_last  <= chunk_last;
                        r_work  <= chunk_first ? IV_HS : r_h;
                        if (chunk_first) r_h <= IV_HS;
                        r_t     <= '0;
                        r_rdy   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ROUNDS;
                    end
                end
                ROUNDS: begin
                    r_work <= w_st[UNROLL];
                    r_w    <= w_nxt;
                    r_t    <= r_t + 7'(UNROLL);
                    if (r_t + 7'(UNROLL) == 7'd64) r_state <= ACCUM;
                end
                ACCUM: begin
                    r_h <= w_sum;
                    if (r_last) begin
                        r_vld    <= 1'b1;
                        r_digest <= w_sum;
                        r_state  <= DIGEST;
                    end else begin
                        r_rdy   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                DIGEST: begin
                    if (digest_rdy) begin
                        r_vld   <= 1'b0;
                        r_h     <= IV_HS;
                        r_rdy   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign chunk_in_rdy = r_rdy;
    assign digest_vld   = r_vld;
    assign digest       = r_digest;
    assign busy         = r_busy;

endmodule

// File: tb/tb_sha256_chunk_hasher.sv
// Directed bench for sha256_chunk_hasher: known-answer digests,
// latency, multi-block contexts, backpressure and async reset.
module tb_sha256_chunk_hasher;

    parameter int UNROLL = 1;
    localparam int LAT = 64 / UNROLL + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         chunk_in_vld = 1'b0;
    logic         chunk_in_rdy;
    logic [511:0] chunk_in = '0;
    logic         chunk_first = 1'b0;
    logic         chunk_last = 1'b0;
    logic         digest_rdy = 1'b1;
    logic         digest_vld;
    logic [255:0] digest;
    logic         busy;

    int checks = 0;
    int errors = 0;

    localparam logic [511:0] ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] EMPTY = {32'h80000000, {15{32'h0}}};
    localparam logic [511:0] TWO1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] TWO2 = {{15{32'h0}}, 32'h000001c0};

    localparam logic [255:0] D_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_TWO =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    sha256_chunk_hasher #(.UNROLL(UNROLL)) dut (
        .clk          (clk),
        .rst          (rst),
        .chunk_in_vld (chunk_in_vld),
        .chunk_in_rdy (chunk_in_rdy),
        .chunk_in     (chunk_in),
        .chunk_first  (chunk_first),
        .chunk_last   (chunk_last),
        .digest_rdy   (digest_rdy),
        .digest_vld   (digest_vld),
        .digest       (digest),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a chunk and returns #1 after its handshake edge
    task automatic send(input logic [511:0] d, input logic f, input logic l);
        int n;
        n = 0;
        chunk_in = d;
        chunk_first = f;
        chunk_last = l;
        chunk_in_vld = 1'b1;
        while (!chunk_in_rdy && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) check("send_timeout", 256'(n), 256'(0));
        @(posedge clk); #1;
        chunk_in_vld = 1'b0;
    endtask

    // Counts cycles from the handshake cycle until digest_vld is seen
    task automatic wait_digest(output int lat);
        lat = 1;
        while (!digest_vld && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 400) check("digest_timeout", 256'(lat), 256'(0));
    endtask

    initial begin
        int lat;
        int hi;
        logic [255:0] held;

        // Reset state
        #2;
        check("rst_rdy", 256'(chunk_in_rdy), 256'(0));
        check("rst_vld", 256'(digest_vld), 256'(0));
        check("rst_digest", digest, 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        check("rdy_after_rel", 256'(chunk_in_rdy), 256'(0));
        @(posedge clk); #1;
        check("rdy_idle", 256'(chunk_in_rdy), 256'(1));

        // "abc" single block, latency
        digest_rdy = 1'b1;
        send(ABC, 1'b1, 1'b1);
        check("busy_rounds", 256'(busy), 256'(1));
        wait_digest(lat);
        check("abc_lat", 256'(lat), 256'(LAT));
        check("abc_digest", digest, D_ABC);
        @(posedge clk); #1;
        check("abc_vld_drop", 256'(digest_vld), 256'(0));
        check("abc_rdy_back", 256'(chunk_in_rdy), 256'(1));

        // Empty message
        send(EMPTY, 1'b1, 1'b1);
        wait_digest(lat);
        check("empty_digest", digest, D_EMPTY);
        @(posedge clk); #1;

        // Two-block message, back to back
        send(TWO1, 1'b1, 1'b0);
        chunk_in = TWO2;
        chunk_first = 1'b0;
        chunk_last = 1'b1;
        chunk_in_vld = 1'b1;
        hi = 0;
        for (int i = 0; i < 64 / UNROLL + 1; i++) begin
            if (chunk_in_rdy || digest_vld) hi++;
            @(posedge clk); #1;
        end
        check("two_rdy_low_b1", 256'(hi), 256'(0));
        check("two_rdy_after_b1", 256'(chunk_in_rdy), 256'(1));
        @(posedge clk); #1;
        chunk_in_vld = 1'b0;
        wait_digest(lat);
        check("two_lat", 256'(lat), 256'(LAT));
        check("two_digest", digest, D_TWO);
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            if (digest_vld) hi++;
            @(posedge clk); #1;
        end
        check("two_one_pulse", 256'(hi), 256'(1));

        // Backpressure on the digest
        digest_rdy = 1'b0;
        send(ABC, 1'b1, 1'b1);
        wait_digest(lat);
        held = digest;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!digest_vld || chunk_in_rdy || digest !== held) hi++;
        end
        check("bp_stable", 256'(hi), 256'(0));
        check("bp_digest", digest, D_ABC);
        digest_rdy = 1'b1;
        @(posedge clk); #1;
        check("bp_vld_drop", 256'(digest_vld), 256'(0));
        check("bp_rdy", 256'(chunk_in_rdy), 256'(1));
        // first=0 here: correct only if H went back to IV
        send(ABC, 1'b0, 1'b1);
        wait_digest(lat);
        check("bp_reload_digest", digest, D_ABC);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a chunk
        send(ABC, 1'b1, 1'b1);
        for (int i = 0; i < 30 / UNROLL; i++) begin
            @(posedge clk); #1;
        end
        check("mid_busy", 256'(busy), 256'(1));
        #2;
        rst = 1'b0;
        #1;
        check("arst_vld", 256'(digest_vld), 256'(0));
        check("arst_busy", 256'(busy), 256'(0));
        check("arst_rdy", 256'(chunk_in_rdy), 256'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        hi = 0;
        for (int i = 0; i < 80; i++) begin
            if (digest_vld) hi++;
            @(posedge clk); #1;
        end
        check("arst_no_partial", 256'(hi), 256'(0));
        send(ABC, 1'b1, 1'b1);
        wait_digest(lat);
        check("arst_abc_digest", digest, D_ABC);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
